csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_if.sv | 34 +++
 rtl/csr_unit.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_csr_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_if.sv
// csr_if: CSR access bus between the instruction pipeline and csr_unit.
// The master issues a CSR access (request, mode, address, operand); the
// slave answers in the same cycle with the pre-write read data and an
// access-fault flag.
interface csr_if #(
    parameter int XLEN = 32
) ();

    logic            csr_req;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_req,
        output csr_op,
        output csr_addr,
        output csr_wdata,
        input  csr_rdata,
        input  csr_illegal
    );

    modport slave (
        input  csr_req,
        input  csr_op,
        input  csr_addr,
        input  csr_wdata,
        output csr_rdata,
        output csr_illegal
    );

endinterface

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file (mstatus, mtvec, mscratch, mepc, mcause,
// mtval) with trap entry, MRET handling and a one-cycle fetch redirect.
// Optional feature: define CSR_COUNTERS_EN to add the 64-bit mcycle and
// minstret counters (0xB00/0xB02, high halves at 0xB80/0xB82 when XLEN=32).
// Without the macro the counter addresses decode as illegal.
module csr_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = XLEN'(32'h0000_0170),
    parameter logic [XLEN-1:0] MEPC_RST  = XLEN'(32'h0001_0000)
) (
    input  logic            clk,
    input  logic            rst,
    csr_if.slave            bus,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    input  logic            retire,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] csr_mtvec,
    output logic [XLEN-1:0] csr_mepc
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam logic [1:0] OP_RO = 2'b00;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    // mepc is always 4-byte aligned; mtvec bit 1 is reserved and reads 0
    localparam logic [XLEN-1:0] MEPC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b01};
    localparam logic [XLEN-1:0] BASE_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } redir_state_t;

    // Read-modify-write combine for RW / RS / RC accesses
    function automatic logic [XLEN-1:0] csr_apply(
        input logic [1:0]      op,
        input logic [XLEN-1:0] old_val,
        input logic [XLEN-1:0] wval
    );
        logic [XLEN-1:0] res;
        res = old_val;
        case (op)
            OP_RW:   res = wval;
            OP_RS:   res = old_val | wval;
            OP_RC:   res = old_val & ~wval;
            default: res = old_val;
        endcase
        return res;
    endfunction

    // Architectural state
    logic            mie_r;
    logic            mpie_r;
    logic [XLEN-1:0] mtvec_r;
    logic [XLEN-1:0] mscratch_r;
    logic [XLEN-1:0] mepc_r;
    logic [XLEN-1:0] mcause_r;
    logic [XLEN-1:0] mtval_r;

    redir_state_t    state_r;
    redir_state_t    state_nxt_s;
    logic [XLEN-1:0] redirect_pc_r;
    logic [XLEN-1:0] redirect_pc_nxt_s;

    logic [XLEN-1:0] mstatus_rd_s;
    logic [XLEN-1:0] rd_val_s;
    logic            addr_hit_s;
    logic            illegal_s;
    logic            wr_en_s;
    logic [XLEN-1:0] wr_val_s;
    logic [XLEN-1:0] trap_base_s;
    logic [XLEN-1:0] trap_target_s;

`ifdef CSR_COUNTERS_EN
    localparam logic [63:0] LO_MASK = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - XLEN);

    logic [63:0] mcycle_r;
    logic [63:0] minstret_r;
    logic        wr_mcycle_lo_s;
    logic        wr_mcycle_hi_s;
    logic        wr_minstret_lo_s;
    logic        wr_minstret_hi_s;
`else
    // retire only feeds the optional instruction counter
    logic        unused_retire_s;
    assign unused_retire_s = retire;
`endif

    // MPP is hardwired to machine mode; only MIE and MPIE hold state
    assign mstatus_rd_s = XLEN'({2'b11, 3'b000, mpie_r, 3'b000, mie_r, 3'b000});

    // Address decode and pre-write read value
    always_comb begin
        addr_hit_s = 1'b0;
        rd_val_s   = '0;
        case (bus.csr_addr)
            ADDR_MSTATUS: begin
                addr_hit_s = 1'b1;
                rd_val_s   = mstatus_rd_s;
            end
            ADDR_MTVEC: begin
                addr_hit_s = 1'b1;
                rd_val_s   = mtvec_r;
            end
            ADDR_MSCRATCH: begin
                addr_hit_s = 1'b1;
                rd_val_s   = mscratch_r;
            end
            ADDR_MEPC: begin
                addr_hit_s = 1'b1;
                rd_val_s   = mepc_r;
            end
            ADDR_MCAUSE: begin
                addr_hit_s = 1'b1;
                rd_val_s   = mcause_r;
            end
            ADDR_MTVAL: begin
                addr_hit_s = 1'b1;
                rd_val_s   = mtval_r;
            end
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE: begin
                addr_hit_s = 1'b1;
                rd_val_s   = mcycle_r[XLEN-1:0];
            end
            ADDR_MINSTRET: begin
                addr_hit_s = 1'b1;
                rd_val_s   = minstret_r[XLEN-1:0];
            end
            ADDR_MCYCLEH: begin
                if (XLEN == 32) begin
                    addr_hit_s = 1'b1;
                    rd_val_s   = XLEN'(mcycle_r >> 32);
                end else begin
                    addr_hit_s = 1'b0;
                    rd_val_s   = '0;
                end
            end
            ADDR_MINSTRETH: begin
                if (XLEN == 32) begin
                    addr_hit_s = 1'b1;
                    rd_val_s   = XLEN'(minstret_r >> 32);
                end else begin
                    addr_hit_s = 1'b0;
                    rd_val_s   = '0;
                end
            end
`endif
            default: begin
                addr_hit_s = 1'b0;
                rd_val_s   = '0;
            end
        endcase
    end

    // Fault: unknown address, or a write-type access to the read-only space
    assign illegal_s = bus.csr_req &&
                       (!addr_hit_s ||
                        ((bus.csr_op != OP_RO) && (bus.csr_addr[11:10] == 2'b11)));

    assign bus.csr_illegal = illegal_s;
    assign bus.csr_rdata   = (bus.csr_req && !illegal_s) ? rd_val_s : '0;

    // RS/RC with a zero operand is a pure read; trap and MRET win over writes
    assign wr_val_s = csr_apply(bus.csr_op, rd_val_s, bus.csr_wdata);
    assign wr_en_s  = bus.csr_req && !illegal_s && !trap_valid && !mret_valid &&
                      ((bus.csr_op == OP_RW) ||
                       (((bus.csr_op == OP_RS) || (bus.csr_op == OP_RC)) &&
                        (bus.csr_wdata != '0)));

    // Trap target: direct base, or base + 4*cause for vectored interrupts
    assign trap_base_s   = mtvec_r & BASE_MASK;
    assign trap_target_s = (mtvec_r[0] && trap_cause[XLEN-1]) ?
                           (trap_base_s + XLEN'({trap_cause[5:0], 2'b00})) :
                           trap_base_s;

    // CSR register file: trap entry, MRET, then software writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_r      <= 1'b0;
            mpie_r     <= 1'b0;
            mtvec_r    <= MTVEC_RST & MTVEC_MASK;
            mscratch_r <= '0;
            mepc_r     <= MEPC_RST & MEPC_MASK;
            mcause_r   <= '0;
            mtval_r    <= '0;
        end else if (trap_valid) begin
            mepc_r   <= trap_pc & MEPC_MASK;
            mcause_r <= trap_cause;
            mtval_r  <= trap_tval;
            mpie_r   <= mie_r;
            mie_r    <= 1'b0;
        end else if (mret_valid) begin
            mie_r  <= mpie_r;
            mpie_r <= 1'b1;
        end else if (wr_en_s) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: begin
                    mie_r  <= wr_val_s[3];
                    mpie_r <= wr_val_s[7];
                end
                ADDR_MTVEC:    mtvec_r    <= wr_val_s & MTVEC_MASK;
                ADDR_MSCRATCH: mscratch_r <= wr_val_s;
                ADDR_MEPC:     mepc_r     <= wr_val_s & MEPC_MASK;
                ADDR_MCAUSE:   mcause_r   <= wr_val_s;
                ADDR_MTVAL:    mtval_r    <= wr_val_s;
                default: begin
                    mie_r <= mie_r;
                end
            endcase
        end else begin
            mie_r <= mie_r;
        end
    end

`ifdef CSR_COUNTERS_EN
    assign wr_mcycle_lo_s   = wr_en_s && (bus.csr_addr == ADDR_MCYCLE);
    assign wr_minstret_lo_s = wr_en_s && (bus.csr_addr == ADDR_MINSTRET);
    assign wr_mcycle_hi_s   = wr_en_s && (bus.csr_addr == ADDR_MCYCLEH);
    assign wr_minstret_hi_s = wr_en_s && (bus.csr_addr == ADDR_MINSTRETH);

    // Counters: a software write replaces that cycle's increment; a
    // half-width write leaves the other half untouched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle_r   <= 64'd0;
            minstret_r <= 64'd0;
        end else begin
            if (wr_mcycle_lo_s) begin
                mcycle_r <= (mcycle_r & ~LO_MASK) | (64'(wr_val_s) & LO_MASK);
            end else if (wr_mcycle_hi_s) begin
                mcycle_r <= (mcycle_r & LO_MASK) | (64'(wr_val_s) << 32);
            end else begin
                mcycle_r <= mcycle_r + 64'd1;
            end

            if (wr_minstret_lo_s) begin
                minstret_r <= (minstret_r & ~LO_MASK) | (64'(wr_val_s) & LO_MASK);
            end else if (wr_minstret_hi_s) begin
                minstret_r <= (minstret_r & LO_MASK) | (64'(wr_val_s) << 32);
            end else if (retire) begin
                minstret_r <= minstret_r + 64'd1;
            end else begin
                minstret_r <= minstret_r;
            end
        end
    end
`endif

    // Redirect FSM next state and next target (trap beats MRET)
    always_comb begin
        state_nxt_s       = ST_IDLE;
        redirect_pc_nxt_s = redirect_pc_r;
        case (state_r)
            ST_IDLE: begin
                if (trap_valid || mret_valid) begin
                    state_nxt_s = ST_REDIRECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (trap_valid || mret_valid) begin
                    state_nxt_s = ST_REDIRECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (trap_valid) begin
            redirect_pc_nxt_s = trap_target_s;
        end else if (mret_valid) begin
            redirect_pc_nxt_s = mepc_r;
        end else begin
            redirect_pc_nxt_s = redirect_pc_r;
        end
    end

    // Redirect FSM state and target registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            redirect_pc_r <= '0;
        end else begin
            state_r       <= state_nxt_s;
            redirect_pc_r <= redirect_pc_nxt_s;
        end
    end

    assign redirect_valid = (state_r == ST_REDIRECT);
    assign redirect_pc    = redirect_pc_r;
    assign csr_mtvec      = mtvec_r;
    assign csr_mepc       = mepc_r;

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed-vector bench for csr_unit (XLEN=32) with
// hand-computed expected values.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_valid;
    logic        retire;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        ill;

    csr_if #(.XLEN(32)) bus_if ();

    csr_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus_if),
        .trap_valid     (trap_valid),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .trap_tval      (trap_tval),
        .mret_valid     (mret_valid),
        .retire         (retire),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One CSR access cycle; called just after a rising edge
    task automatic csr_cycle(input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] wd,
                             output logic [31:0] rdo, output logic illo);
        bus_if.csr_req   = 1'b1;
        bus_if.csr_op    = op;
        bus_if.csr_addr  = addr;
        bus_if.csr_wdata = wd;
        #2;
        rdo  = bus_if.csr_rdata;
        illo = bus_if.csr_illegal;
        @(posedge clk);
        #1;
        bus_if.csr_req   = 1'b0;
        bus_if.csr_op    = 2'b00;
        bus_if.csr_addr  = 12'h000;
        bus_if.csr_wdata = 32'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        i;
        csr_cycle(2'b00, addr, 32'h0, r, i);
        check_eq(tag, {32'h0, r}, {32'h0, exp});
    endtask

    task automatic wr_chk(input string tag, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_old);
        logic [31:0] r;
        logic        i;
        csr_cycle(op, addr, wd, r, i);
        check_eq(tag, {32'h0, r}, {32'h0, exp_old});
        check_eq({tag, "_ill"}, {63'h0, i}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst              = 1'b0;
        trap_valid       = 1'b0;
        trap_cause       = 32'h0;
        trap_pc          = 32'h0;
        trap_tval        = 32'h0;
        mret_valid       = 1'b0;
        retire           = 1'b0;
        bus_if.csr_req   = 1'b0;
        bus_if.csr_op    = 2'b00;
        bus_if.csr_addr  = 12'h000;
        bus_if.csr_wdata = 32'h0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rv", {63'h0, redirect_valid}, 64'h0);
        check_eq("rst_rpc", {32'h0, redirect_pc}, 64'h0);
        check_eq("rst_mtvec_out", {32'h0, csr_mtvec}, 64'h170);
        check_eq("rst_mepc_out", {32'h0, csr_mepc}, 64'h1_0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("rst_mtvec", 12'h305, 32'h0000_0170);
        rd_chk("rst_mepc", 12'h341, 32'h0001_0000);
        rd_chk("rst_mscratch", 12'h340, 32'h0);
        rd_chk("rst_mcause", 12'h342, 32'h0);
        rd_chk("rst_mtval", 12'h343, 32'h0);
        check_eq("rst_rv_after", {63'h0, redirect_valid}, 64'h0);

        // RW / RS / RC sequence on mscratch
        wr_chk("rw_scr", 2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0);
        rd_chk("rd_scr1", 12'h340, 32'hDEAD_BEEF);
        wr_chk("rs_scr", 2'b10, 12'h340, 32'h0000_0010, 32'hDEAD_BEEF);
        wr_chk("rc_scr", 2'b11, 12'h340, 32'hDEAD_0000, 32'hDEAD_BEFF);
        rd_chk("rd_scr2", 12'h340, 32'h0000_BEFF);
        wr_chk("rs0_scr", 2'b10, 12'h340, 32'h0, 32'h0000_BEFF);
        rd_chk("rd_scr3", 12'h340, 32'h0000_BEFF);

        // mstatus field masking
        wr_chk("rw_mst", 2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800);
        rd_chk("rd_mst1", 12'h300, 32'h0000_1888);
        wr_chk("rc_mst", 2'b11, 12'h300, 32'hFFFF_FFFF, 32'h0000_1888);
        rd_chk("rd_mst2", 12'h300, 32'h0000_1800);

        // mepc / mtvec low-bit masking
        wr_chk("rw_mepc", 2'b01, 12'h341, 32'h1234_5677, 32'h0001_0000);
        rd_chk("rd_mepc", 12'h341, 32'h1234_5674);
        check_eq("mepc_out", {32'h0, csr_mepc}, 64'h1234_5674);
        wr_chk("rw_mtvec", 2'b01, 12'h305, 32'h0000_0103, 32'h0000_0170);
        rd_chk("rd_mtvec", 12'h305, 32'h0000_0101);
        check_eq("mtvec_out", {32'h0, csr_mtvec}, 64'h101);

        // Set MIE, then take a vectored interrupt trap
        wr_chk("rs_mie", 2'b10, 12'h300, 32'h0000_0008, 32'h0000_1800);
        rd_chk("rd_mst3", 12'h300, 32'h0000_1808);
        trap_valid = 1'b1;
        trap_cause = 32'h8000_0007;
        trap_pc    = 32'h0000_0200;
        trap_tval  = 32'h0000_0ABC;
        @(posedge clk);
        #1;
        trap_valid = 1'b0;
        check_eq("trap_rv", {63'h0, redirect_valid}, 64'h1);
        check_eq("trap_rpc", {32'h0, redirect_pc}, 64'h11C);
        @(posedge clk);
        #1;
        check_eq("trap_rv_end", {63'h0, redirect_valid}, 64'h0);
        rd_chk("trap_mepc", 12'h341, 32'h0000_0200);
        rd_chk("trap_mcause", 12'h342, 32'h8000_0007);
        rd_chk("trap_mtval", 12'h343, 32'h0000_0ABC);
        rd_chk("trap_mst", 12'h300, 32'h0000_1880);

        // MRET back to mepc
        mret_valid = 1'b1;
        @(posedge clk);
        #1;
        mret_valid = 1'b0;
        check_eq("mret_rv", {63'h0, redirect_valid}, 64'h1);
        check_eq("mret_rpc", {32'h0, redirect_pc}, 64'h200);
        @(posedge clk);
        #1;
        check_eq("mret_rv_end", {63'h0, redirect_valid}, 64'h0);
        rd_chk("mret_mst", 12'h300, 32'h0000_1888);

        // Trap + MRET + CSR write in one cycle: trap wins, write dropped
        trap_valid       = 1'b1;
        trap_cause       = 32'h0000_0002;
        trap_pc          = 32'h0000_0300;
        trap_tval        = 32'h0;
        mret_valid       = 1'b1;
        bus_if.csr_req   = 1'b1;
        bus_if.csr_op    = 2'b01;
        bus_if.csr_addr  = 12'h340;
        bus_if.csr_wdata = 32'h0000_1111;
        #2;
        check_eq("prio_ill", {63'h0, bus_if.csr_illegal}, 64'h0);
        @(posedge clk);
        #1;
        trap_valid     = 1'b0;
        mret_valid     = 1'b0;
        bus_if.csr_req = 1'b0;
        bus_if.csr_op  = 2'b00;
        check_eq("prio_rv", {63'h0, redirect_valid}, 64'h1);
        check_eq("prio_rpc", {32'h0, redirect_pc}, 64'h100);
        @(posedge clk);
        #1;
        check_eq("prio_rv_end", {63'h0, redirect_valid}, 64'h0);
        rd_chk("prio_mepc", 12'h341, 32'h0000_0300);
        rd_chk("prio_mst", 12'h300, 32'h0000_1880);
        rd_chk("prio_scr", 12'h340, 32'h0000_BEFF);

        // Trap then MRET on consecutive cycles: redirect stays up, new target
        trap_valid = 1'b1;
        trap_cause = 32'h0000_0003;
        trap_pc    = 32'h0000_0400;
        @(posedge clk);
        #1;
        trap_valid = 1'b0;
        mret_valid = 1'b1;
        check_eq("b2b_rv1", {63'h0, redirect_valid}, 64'h1);
        check_eq("b2b_rpc1", {32'h0, redirect_pc}, 64'h100);
        @(posedge clk);
        #1;
        mret_valid = 1'b0;
        check_eq("b2b_rv2", {63'h0, redirect_valid}, 64'h1);
        check_eq("b2b_rpc2", {32'h0, redirect_pc}, 64'h400);
        @(posedge clk);
        #1;
        check_eq("b2b_rv3", {63'h0, redirect_valid}, 64'h0);
        rd_chk("b2b_mst", 12'h300, 32'h0000_1880);

        // Illegal accesses: no data, no state change
        csr_cycle(2'b00, 12'h7C0, 32'h0, rd, ill);
        check_eq("ill_7c0", {63'h0, ill}, 64'h1);
        check_eq("ill_7c0_rd", {32'h0, rd}, 64'h0);
        csr_cycle(2'b01, 12'hF11, 32'hFFFF_FFFF, rd, ill);
        check_eq("ill_f11", {63'h0, ill}, 64'h1);
        check_eq("ill_f11_rd", {32'h0, rd}, 64'h0);
        csr_cycle(2'b00, 12'h344, 32'h0, rd, ill);
        check_eq("ill_344", {63'h0, ill}, 64'h1);
        check_eq("ill_344_rd", {32'h0, rd}, 64'h0);
        rd_chk("ill_scr", 12'h340, 32'h0000_BEFF);
        rd_chk("ill_mtvec", 12'h305, 32'h0000_0101);

`ifdef CSR_COUNTERS_EN
        // mcycle low-half wrap carries into the high half
        csr_cycle(2'b01, 12'hB00, 32'hFFFF_FFFF, rd, ill);
        check_eq("cyc_wr_ill", {63'h0, ill}, 64'h0);
        rd_chk("cyc_lo_max", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("cyc_lo_wrap", 12'hB00, 32'h0);
        rd_chk("cyc_hi", 12'hB80, 32'h1);
        csr_cycle(2'b01, 12'hB00, 32'h5, rd, ill);
        rd_chk("cyc_wr5", 12'hB00, 32'h5);
        retire = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        retire = 1'b0;
        rd_chk("instret", 12'hB02, 32'h3);
`else
        csr_cycle(2'b00, 12'hB00, 32'h0, rd, ill);
        check_eq("nocnt_b00", {63'h0, ill}, 64'h1);
        csr_cycle(2'b00, 12'hB82, 32'h0, rd, ill);
        check_eq("nocnt_b82", {63'h0, ill}, 64'h1);
`endif

        // Reset during a redirect pulse cancels it
        trap_valid = 1'b1;
        trap_cause = 32'h0;
        trap_pc    = 32'h0000_0500;
        @(posedge clk);
        #1;
        trap_valid = 1'b0;
        check_eq("mid_rv", {63'h0, redirect_valid}, 64'h1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_rv", {63'h0, redirect_valid}, 64'h0);
        check_eq("mid_rst_rpc", {32'h0, redirect_pc}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd_chk("mid_mst", 12'h300, 32'h0000_1800);
        rd_chk("mid_mepc", 12'h341, 32'h0001_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
